ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the small single-port r/w RAM (4 words x 4 bits).
//  Shares the RAM between two requesters (e.g. switch-driven user port and a pattern/scan engine).
//  Serialises their read/write commands with a req/gnt/rvalid handshake.
//  Zero-fills the RAM after every reset.
//  Sits between board-level request logic and the RAM; drives LED/LCD debug status.
// PARAMETERS
//  NREQ        2   number of requesters (design and test fixed at 2)
//  NBITS_DATA  4   data word width
//  NBITS_ADDR  2   address width; depth = 2**NBITS_ADDR = 4
// PORTS
//  clk_2   in   1                  system clock; all state on posedge
//  reset   in   1                  synchronous, active-high reset
//  req     in   NREQ               request; held with cmd fields until gnt seen
//  we      in   NREQ               1 = write, 0 = read (per requester)
//  addr    in   NREQ*NBITS_ADDR    address per requester; [i*A +: A]
//  wdata   in   NREQ*NBITS_DATA    write data per requester; [i*D +: D]
//  gnt     out  NREQ               one-hot, 1-cycle pulse: command accepted
//  rvalid  out  NREQ               one-hot, 1-cycle pulse: rdata valid for that requester
//  rdata   out  NBITS_DATA         last read data; holds between reads
//  busy    out  1                  high while clearing or servicing a command
//  state_o out  2                  encoded FSM state for LED/LCD debug
// BEHAVIOUR
//  Reset (sync, active-high)
//   - state=CLEAR, clr_ptr=0, last=1, gnt=0, rvalid=0, rdata=0, busy=1.
//   - Any in-flight command is dropped.
//  CLEAR
//   - Writes 0 to mem[clr_ptr] each cycle; clr_ptr++.
//   - After writing addr 2**NBITS_ADDR-1 -> IDLE; total 4 cycles.
//   - req ignored, no gnt.
//  IDLE (busy=0)
//   - No req: stay.
//   - One req: that requester wins.
//   - Both req: winner = ~last (round-robin; req0 wins the first tie after reset).
//   - On the edge: latch sel/we/addr/wdata into cmd regs, last<=winner, gnt[winner]<=1, -> ACCESS.
//  ACCESS (gnt[sel]=1 this cycle, busy=1)
//   - Write: mem[cmd_addr]<=cmd_wdata at end of cycle, -> IDLE.
//   - Read: rdata<=mem[cmd_addr], rvalid[sel]<=1, -> RESP.
//  RESP (rvalid[sel]=1 this cycle, busy=1)
//   - -> IDLE.
//  Latency, from the edge that samples req in IDLE:
//   - gnt 1 cycle later.
//   - Read: rvalid 2 cycles later. Write: visible to a read granted in the next IDLE.
//   - Throughput: write 2 cycles/command, read 3 cycles/command.
//  Requester protocol
//   - Drop req in the cycle gnt is seen, or it is treated as a new request.
//   - cmd fields are sampled only at the IDLE->ACCESS edge; later changes have no effect.
//  Boundary cases
//   - Simultaneous, both held high: strict alternation 0,1,0,1.
//   - Write by one requester and read by the other to the same address: ordered purely by arbitration.
//   - gnt and rvalid are never high in the same cycle; never more than 1 bit set.
//   - All addresses are in range (full decode), so no illegal-address case exists.
//   - Reset in any state: next cycle is CLEAR with the reset values above.
//  Encodings
//   - state_o: CLEAR=0, IDLE=1, ACCESS=2, RESP=3.
// STRUCTURE
//  ram_arb_pkg
//   - typedef enum logic[1:0] arb_state_t {CLEAR, IDLE, ACCESS, RESP}.
//   - Default constants for NBITS_DATA / NBITS_ADDR.
//  ram_sp (sub-module)
//   - Single-port synchronous RAM, 2**A x D, inputs we, addr, wdata.
//   - Registered read, captured on the same edge as the write decision.
//  ram_arbiter
//   - FSM, round-robin pointer, cmd regs, clear counter.
//   - Mux that drives ram_sp from the clear counter or the cmd regs.
// TESTING
//  1. Reset 1 cycle, release -> busy=1 for 4 cycles, state_o 0 then 1.
//     Then req0 read addr2 -> gnt[0], next cycle rvalid[0], rdata=0.
//  2. req0 write addr1=0xA -> gnt[0] 1 cycle after sampling, busy back to 0 after 2 cycles.
//     Then req1 read addr1 -> rvalid[1]=1, rvalid[0]=0, rdata=0xA.
//  3. After reset, req0 and req1 held high with reads of addr0 -> gnt sequence 0,1,0,1.
//     Each rvalid matches its gnt; gnt and rvalid never overlap.
//  4. Same cycle: req0 read addr3, req1 write addr3=0x5, last=0 -> gnt[1] first (write).
//     Then gnt[0]; rvalid[0] with rdata=0x5.
//  5. Fill all 4 addresses with 0xF; req0 write addr3=0x1, assert reset during ACCESS.
//     -> gnt=0, rvalid=0 next cycle; CLEAR runs; reads of addrs 0-3 all return 0.
//  6. req1 high during CLEAR -> no gnt until busy falls.
//     gnt[1] exactly 1 cycle after the first IDLE cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
// Holds the FSM state encoding and the round-robin pick function.
package ram_arb_pkg;

    localparam int NREQ_DEF       = 2;
    localparam int NBITS_DATA_DEF = 4;
    localparam int NBITS_ADDR_DEF = 2;

    // Encoding is visible on the debug port, so values are pinned.
    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Winner index for two requesters; on a tie the one that did not win last time goes.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic winner;
        if (req[0] && req[1]) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
        return winner;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, 2**NBITS_ADDR words of NBITS_DATA bits.
// Read data is registered and holds its value until the next read.
module ram_sp #(
    parameter int NBITS_DATA = 4,
    parameter int NBITS_ADDR = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [NBITS_ADDR-1:0] i_addr,
    input  logic [NBITS_DATA-1:0] i_wdata,
    output logic [NBITS_DATA-1:0] o_rdata
);

    logic [NBITS_DATA-1:0] r_mem [2**NBITS_ADDR];
    logic [NBITS_DATA-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one small RAM between two requesters.
// Zero-fills the RAM after reset, then serialises read/write commands.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int NBITS_DATA = NBITS_DATA_DEF,
    parameter int NBITS_ADDR = NBITS_ADDR_DEF
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            we,
    input  logic [NREQ*NBITS_ADDR-1:0] addr,
    input  logic [NREQ*NBITS_DATA-1:0] wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [NBITS_DATA-1:0]      rdata,
    output logic                       busy,
    output logic [1:0]                 state_o
);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [NBITS_ADDR-1:0]   r_clr_ptr;
    logic                    r_last;
    logic                    r_sel;
    logic                    r_cmd_we;
    logic [NBITS_ADDR-1:0]   r_cmd_addr;
    logic [NBITS_DATA-1:0]   r_cmd_wdata;

    logic                    w_winner;
    logic                    w_accept;
    logic [NREQ-1:0]         w_sel_onehot;
    logic                    w_ram_en;
    logic                    w_ram_we;
    logic [NBITS_ADDR-1:0]   w_ram_addr;
    logic [NBITS_DATA-1:0]   w_ram_wdata;

    assign w_winner = rr_pick(req, r_last);
    assign w_accept = (r_state == IDLE) && (|req);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (r_clr_ptr == '1) w_next_state = IDLE;
            IDLE:    if (|req) w_next_state = ACCESS;
            ACCESS:  w_next_state = r_cmd_we ? IDLE : RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= '0;
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            if (w_accept) begin
                r_sel       <= w_winner;
                r_last      <= w_winner;
                r_cmd_we    <= we[int'(w_winner)];
                r_cmd_addr  <= addr[int'(w_winner)*NBITS_ADDR +: NBITS_ADDR];
                r_cmd_wdata <= wdata[int'(w_winner)*NBITS_DATA +: NBITS_DATA];
            end
        end
    end

    // The RAM is held off during reset so an in-flight write is dropped, not committed.
    assign w_ram_en    = !reset && ((r_state == CLEAR) || (r_state == ACCESS));
    assign w_ram_we    = (r_state == CLEAR) ? 1'b1 : r_cmd_we;
    assign w_ram_addr  = (r_state == CLEAR) ? r_clr_ptr : r_cmd_addr;
    assign w_ram_wdata = (r_state == CLEAR) ? '0 : r_cmd_wdata;

    ram_sp #(
        .NBITS_DATA (NBITS_DATA),
        .NBITS_ADDR (NBITS_ADDR)
    ) u_ram (
        .i_clk   (clk_2),
        .i_reset (reset),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (rdata)
    );

    // gnt and rvalid decode straight from registered state, so they cannot overlap.
    assign w_sel_onehot = NREQ'(1) << r_sel;
    assign gnt          = (r_state == ACCESS) ? w_sel_onehot : '0;
    assign rvalid       = (r_state == RESP) ? w_sel_onehot : '0;
    assign busy         = (r_state != IDLE);
    assign state_o      = r_state;

endmodule
